bus_lv1_lv2_arbiter: RTL and testbench



---
 rtl/bus_lv1_lv2_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bus_lv1_lv2_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bus_lv1_lv2_arbiter.sv
// rtl/bus_lv1_lv2_arbiter.sv - round-robin owner arbiter for the shared L1-L2 bus with snoop/L2 secondary grants
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   bus_lv1_lv2_req_proc  [N]    ownership request per L1 (index = core*2 + {0:DL,1:IL})
//   bus_lv1_lv2_gnt_proc  [N]    registered ownership grant, one-hot or zero
//   bus_lv1_lv2_req_snoop [N]    snoop writeback request per L1
//   bus_lv1_lv2_gnt_snoop [N]    registered snoop grant, one-hot or zero
//   bus_lv1_lv2_req_lv2          L2 data-drive request
//   bus_lv1_lv2_gnt_lv2          registered L2 data-drive grant
//   bus_owner   [PROC_WID]       current or last owner index
//   arb_timeout                  sticky watchdog flag
//
// Optional feature: define ARB_TIMEOUT_EN to enable the ownership watchdog
// (TIMEOUT cycles in any owned state forces the bus back to IDLE).
module bus_lv1_lv2_arbiter #(
    parameter int NUM_PROC    = 8,
    parameter int PROC_WID    = 3,
    parameter int TIMEOUT     = 255,
    parameter int TIMEOUT_WID = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PROC-1:0] bus_lv1_lv2_req_proc,
    output logic [NUM_PROC-1:0] bus_lv1_lv2_gnt_proc,
    input  logic [NUM_PROC-1:0] bus_lv1_lv2_req_snoop,
    output logic [NUM_PROC-1:0] bus_lv1_lv2_gnt_snoop,
    input  logic                bus_lv1_lv2_req_lv2,
    output logic                bus_lv1_lv2_gnt_lv2,
    output logic [PROC_WID-1:0] bus_owner,
    output logic                arb_timeout
);

    typedef enum logic [1:0] {IDLE, OWN, OWN_SNOOP, OWN_LV2} state_t;

    localparam logic [NUM_PROC-1:0] ONE = NUM_PROC'(1);

    state_t              state, state_next;
    logic [PROC_WID-1:0] rr_ptr, rr_next, owner_next;
    logic [PROC_WID-1:0] snoop_idx, snoop_next;
    logic [PROC_WID-1:0] rr_win, snoop_win, idx;
    logic                rr_found, snoop_any, owner_req, wd_expire;
    logic [NUM_PROC-1:0] snoop_mask;
    logic [NUM_PROC-1:0] gnt_proc_next, gnt_snoop_next;
    logic                gnt_lv2_next;

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        rr_win   = '0;
        rr_found = 1'b0;
        idx      = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            idx = PROC_WID'((int'(rr_ptr) + i) % NUM_PROC);
            if (!rr_found && bus_lv1_lv2_req_proc[idx]) begin
                rr_win   = idx;
                rr_found = 1'b1;
            end
        end
    end

    // The owner's own snoop bit never competes; lowest remaining index wins.
    assign snoop_mask = bus_lv1_lv2_req_snoop & ~(ONE << bus_owner);
    assign snoop_any  = |snoop_mask;
    assign owner_req  = bus_lv1_lv2_req_proc[bus_owner];

    always_comb begin
        snoop_win = '0;
        for (int i = NUM_PROC - 1; i >= 0; i--) begin
            if (snoop_mask[i]) snoop_win = PROC_WID'(i);
        end
    end

    always_comb begin
        state_next = state;
        owner_next = bus_owner;
        rr_next    = rr_ptr;
        snoop_next = snoop_idx;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    state_next = OWN;
                    owner_next = rr_win;
                    rr_next    = (rr_win == PROC_WID'(NUM_PROC - 1)) ? '0 : rr_win + 1'b1;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    state_next = IDLE;
                end else if (snoop_any) begin
                    state_next = OWN_SNOOP;
                    snoop_next = snoop_win;
                end else if (bus_lv1_lv2_req_lv2) begin
                    state_next = OWN_LV2;
                end
            end
            OWN_SNOOP: begin
                if (!owner_req) state_next = IDLE;
                else if (!bus_lv1_lv2_req_snoop[snoop_idx]) state_next = OWN;
            end
            OWN_LV2: begin
                if (!owner_req) state_next = IDLE;
                else if (!bus_lv1_lv2_req_lv2) state_next = OWN;
            end
            default: state_next = IDLE;
        endcase
        if (wd_expire) state_next = IDLE;

        // Grants are decoded from next state so the outputs come straight from flops.
        gnt_proc_next  = (state_next != IDLE) ? (ONE << owner_next) : '0;
        gnt_snoop_next = (state_next == OWN_SNOOP) ? (ONE << snoop_next) : '0;
        gnt_lv2_next   = (state_next == OWN_LV2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            bus_owner             <= '0;
            rr_ptr                <= '0;
            snoop_idx             <= '0;
            bus_lv1_lv2_gnt_proc  <= '0;
            bus_lv1_lv2_gnt_snoop <= '0;
            bus_lv1_lv2_gnt_lv2   <= 1'b0;
        end else begin
            state                 <= state_next;
            bus_owner             <= owner_next;
            rr_ptr                <= rr_next;
            snoop_idx             <= snoop_next;
            bus_lv1_lv2_gnt_proc  <= gnt_proc_next;
            bus_lv1_lv2_gnt_snoop <= gnt_snoop_next;
            bus_lv1_lv2_gnt_lv2   <= gnt_lv2_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [TIMEOUT_WID-1:0] wd_cnt;
    logic                   timeout_flag;

    // Counter holds 0 while idle, so every new ownership starts from 0.
    // Expiry on the edge that would bring the count to TIMEOUT.
    assign wd_expire   = (state != IDLE) && (wd_cnt == TIMEOUT_WID'(TIMEOUT - 1));
    assign arb_timeout = timeout_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == IDLE) wd_cnt <= '0;
            else if (wd_cnt != TIMEOUT_WID'(TIMEOUT)) wd_cnt <= wd_cnt + 1'b1;
            if (wd_expire) timeout_flag <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign wd_expire          = 1'b0;
    assign arb_timeout        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_WID'(TIMEOUT);
`endif

endmodule

// File: tb/tb_bus_lv1_lv2_arbiter.sv
// tb/tb_bus_lv1_lv2_arbiter.sv - directed self-checking bench for bus_lv1_lv2_arbiter
module tb_bus_lv1_lv2_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_proc, gnt_proc, req_snoop, gnt_snoop;
    logic       req_lv2, gnt_lv2, arb_timeout;
    logic [2:0] bus_owner;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_lv1_lv2_arbiter #(
        .NUM_PROC(8), .PROC_WID(3), .TIMEOUT(TB_TIMEOUT), .TIMEOUT_WID(8)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .bus_lv1_lv2_req_proc (req_proc),
        .bus_lv1_lv2_gnt_proc (gnt_proc),
        .bus_lv1_lv2_req_snoop(req_snoop),
        .bus_lv1_lv2_gnt_snoop(gnt_snoop),
        .bus_lv1_lv2_req_lv2  (req_lv2),
        .bus_lv1_lv2_gnt_lv2  (gnt_lv2),
        .bus_owner            (bus_owner),
        .arb_timeout          (arb_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] oh(input int i);
        logic [7:0] one;
        one = 8'd1;
        return one << i;
    endfunction

    // Advance one clock, sample 1ns after the edge, and check the bus invariants.
    task automatic step();
        @(posedge clk);
        #1;
        if (!rst) begin
            check("mutex_snoop_lv2", {31'd0, (|gnt_snoop) && gnt_lv2}, 32'd0);
            check("secondary_needs_owner", {31'd0, ((|gnt_snoop) || gnt_lv2) && (gnt_proc == 8'd0)}, 32'd0);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt_proc"}, gnt_proc, 0);
        check({tag, "_gnt_snoop"}, gnt_snoop, 0);
        check({tag, "_gnt_lv2"}, gnt_lv2, 0);
    endtask

    int exp_own[4] = '{0, 7, 0, 7};

    initial begin
        rst = 1'b1; req_proc = '0; req_snoop = '0; req_lv2 = 1'b0;
        step(); step();
        check_idle("reset");
        check("reset_owner", bus_owner, 0);
        check("reset_timeout", arb_timeout, 0);
        rst = 1'b0;
        step();
        check_idle("idle_no_req");

        // Round robin between requesters 0 and 7, one idle cycle between owners.
        req_proc = 8'b1000_0001;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_gnt", gnt_proc, oh(exp_own[k]));
            check("rr_owner", bus_owner, exp_own[k]);
            step(); step();
            check("rr_hold", gnt_proc, oh(exp_own[k]));
            req_proc[exp_own[k]] = 1'b0;
            step();
            check_idle("rr_release");
            req_proc[exp_own[k]] = 1'b1;
        end
        req_proc = '0;
        step();

        // Snoop beats L2; L2 follows after one plain OWN cycle.
        req_proc = 8'b0000_0100;
        step();
        check("sn_owner2", gnt_proc, 8'h04);
        req_snoop = 8'b0001_0000; req_lv2 = 1'b1;
        step();
        check("sn_gnt_snoop", gnt_snoop, 8'h10);
        check("sn_lv2_waits", gnt_lv2, 0);
        req_snoop = '0;
        step();
        check("sn_own_gap_snoop", gnt_snoop, 0);
        check("sn_own_gap_lv2", gnt_lv2, 0);
        check("sn_own_gap_proc", gnt_proc, 8'h04);
        step();
        check("sn_gnt_lv2", gnt_lv2, 1);
        req_proc = '0;
        step();
        check_idle("sn_release");
        req_lv2 = 1'b0;
        step();

        // Owner 1 drops mid-snoop: everything clears even with snoop still requesting.
        req_proc = 8'b0000_0010;
        step();
        check("mid_owner1", bus_owner, 1);
        req_snoop = 8'b0100_0000;
        step();
        check("mid_gnt_snoop", gnt_snoop, 8'h40);
        req_proc = '0;
        step();
        check_idle("mid_release");
        req_snoop = '0;
        step();

        // Owner self-snoop ignored; another snooper is still served.
        req_proc = 8'b0000_1000;
        step();
        check("self_owner3", gnt_proc, 8'h08);
        req_snoop = 8'b0000_1000;
        step(); step();
        check("self_snoop_ignored", gnt_snoop, 0);
        req_snoop = 8'b0000_1001;
        step();
        check("self_other_snoop", gnt_snoop, 8'h01);
        req_proc = '0; req_snoop = '0;
        step();
        check_idle("self_release");

        // Reset during OWN_LV2 with owner 5.
        req_proc = 8'b0010_0000;
        step();
        check("rst_owner5", bus_owner, 5);
        req_lv2 = 1'b1;
        step();
        check("rst_lv2", gnt_lv2, 1);
        rst = 1'b1;
        step();
        check_idle("rst_mid");
        check("rst_mid_owner", bus_owner, 0);
        rst = 1'b0; req_lv2 = 1'b0; req_proc = 8'hff;
        step();
        check("rst_first_gnt", gnt_proc, 8'h01);
        req_proc = '0;
        step();

`ifdef ARB_TIMEOUT_EN
        // Watchdog: owner 0 holds forever, requester 1 waiting.
        rst = 1'b1;
        step();
        rst = 1'b0; req_proc = 8'b0000_0011;
        step();
        check("wd_gnt0", gnt_proc, 8'h01);
        for (int k = 0; k < TB_TIMEOUT - 1; k++) step();
        check("wd_still_held", gnt_proc, 8'h01);
        check("wd_not_yet", arb_timeout, 0);
        step();
        check("wd_forced_idle", gnt_proc, 0);
        check("wd_flag", arb_timeout, 1);
        step();
        check("wd_next_owner", gnt_proc, 8'h02);
        check("wd_flag_sticky", arb_timeout, 1);
        req_proc = '0;
        step(); step();
        check("wd_flag_sticky2", arb_timeout, 1);
`else
        // Without the watchdog an owner keeps the bus indefinitely.
        req_proc = 8'b0000_0011;
        step();
        check("hold_gnt", gnt_proc, 8'h02);
        for (int k = 0; k < 40; k++) step();
        check("hold_forever", gnt_proc, 8'h02);
        check("hold_no_timeout", arb_timeout, 0);
        req_proc = '0;
        step();
        check_idle("hold_release");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
